muldiv_sequencer: RTL and testbench

MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

---
 rtl/muldiv_pkg.sv | 36 +++
 rtl/muldiv_sequencer_if.sv | 41 ++++
 rtl/muldiv_step.sv | 55 +++++
 rtl/muldiv_sequencer.sv | 171 +++++++++++++++++
 tb/tb_muldiv_sequencer.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/muldiv_pkg.sv
// -----------------------------------------------------------------------------
// muldiv_pkg
// Shared definitions for the multiply/divide sequencer:
//   XLEN     - default operand / HI / LO width
//   op_e     - Op encoding presented by EXE (mult, multu, div, divu)
//   state_e  - sequencer states IDLE -> RUN -> FIX -> DONE
//   helpers  - decode of the Op field into divide / signed flags
// -----------------------------------------------------------------------------
package muldiv_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_FIX  = 2'b10,
    S_DONE = 2'b11
  } state_e;

  function automatic logic op_is_div(input op_e op);
    return op[1];
  endfunction

  // Bit 0 set marks the unsigned variant of both mult and div.
  function automatic logic op_is_signed(input op_e op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/muldiv_sequencer_if.sv
// -----------------------------------------------------------------------------
// muldiv_sequencer_if
// Handshake bundle between the EXE stage (master) and the sequencer (slave).
//   Start        EXE -> seq   request a mult/div instruction
//   Op           EXE -> seq   00 mult, 01 multu, 10 div, 11 divu
//   Rs_data      EXE -> seq   multiplicand / dividend
//   Rt_data      EXE -> seq   multiplier / divisor
//   HILO_read    ID  -> seq   mfhi/mflo waiting in ID
//   Busy         seq -> pipe  sequencer not in IDLE
//   MulDiv_stall seq -> pipe  stall PC, IF/ID and ID/EXE
//   Done         seq -> pipe  one-cycle completion pulse
//   Div_by_zero  seq -> pipe  pulses with Done on a zero divisor
//   HI, LO       seq -> pipe  architectural HI/LO registers
// -----------------------------------------------------------------------------
interface muldiv_sequencer_if #(
  parameter int XLEN = muldiv_pkg::XLEN
);

  logic            Start;
  logic [1:0]      Op;
  logic [XLEN-1:0] Rs_data;
  logic [XLEN-1:0] Rt_data;
  logic            HILO_read;
  logic            Busy;
  logic            MulDiv_stall;
  logic            Done;
  logic            Div_by_zero;
  logic [XLEN-1:0] HI;
  logic [XLEN-1:0] LO;

  modport master (
    output Start, Op, Rs_data, Rt_data, HILO_read,
    input  Busy, MulDiv_stall, Done, Div_by_zero, HI, LO
  );

  modport slave (
    input  Start, Op, Rs_data, Rt_data, HILO_read,
    output Busy, MulDiv_stall, Done, Div_by_zero, HI, LO
  );

endinterface

// File: rtl/muldiv_step.sv
// -----------------------------------------------------------------------------
// muldiv_step
// Combinational single iteration of the unsigned magnitude datapath.
//   Multiply (shift-add):  acc += opa when opb[0]; opa <<= 1; opb >>= 1
//   Divide (restoring):    {rem,quo} <<= 1; if rem >= divisor then
//                          rem -= divisor and quotient bit = 1
// Ports:
//   i_is_div  select divide step instead of multiply step
//   i_acc     multiply: partial product; divide: {remainder, dividend/quotient}
//   i_opa     multiply: shifted multiplicand; divide: divisor in low XLEN bits
//   i_opb     multiply: remaining multiplier (unused for divide)
//   o_*       the same registers after one step
// -----------------------------------------------------------------------------
module muldiv_step #(
  parameter int XLEN = muldiv_pkg::XLEN
) (
  input  logic              i_is_div,
  input  logic [2*XLEN-1:0] i_acc,
  input  logic [2*XLEN-1:0] i_opa,
  input  logic [XLEN-1:0]   i_opb,
  output logic [2*XLEN-1:0] o_acc,
  output logic [2*XLEN-1:0] o_opa,
  output logic [XLEN-1:0]   o_opb
);

  // The shifted partial remainder needs one extra bit; the top bit of the
  // difference is then a clean borrow flag.
  logic [XLEN:0] w_rem_sh;
  logic [XLEN:0] w_diff;

  always_comb begin
    // NOTE: every output gets a default first so no branch can leave one
    // unassigned, which would otherwise infer a latch.
    o_acc    = i_acc;
    o_opa    = i_opa;
    o_opb    = i_opb;
    w_rem_sh = i_acc[2*XLEN-1:XLEN-1];
    w_diff   = w_rem_sh - {1'b0, i_opa[XLEN-1:0]};

    if (i_is_div) begin
      if (!w_diff[XLEN]) begin
        o_acc = {w_diff[XLEN-1:0], i_acc[XLEN-2:0], 1'b1};
      end else begin
        o_acc = {w_rem_sh[XLEN-1:0], i_acc[XLEN-2:0], 1'b0};
      end
    end else begin
      if (i_opb[0]) begin
        o_acc = i_acc + i_opa;
      end
      o_opa = {i_opa[2*XLEN-2:0], 1'b0};
      o_opb = {1'b0, i_opb[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// -----------------------------------------------------------------------------
// muldiv_sequencer
// Multi-cycle MIPS-style mult/multu/div/divu unit owning HI/LO.
// Flow: IDLE -(Start)-> RUN (32 steps) -> FIX (sign correction) -> DONE -> IDLE.
// A div/divu with a zero divisor goes IDLE -> DONE directly with
// HI = Rs_data, LO = all ones and Div_by_zero pulsing with Done.
// Ports:
//   Clk    rising-edge clock
//   Rst_n  asynchronous active-low reset
//   bus    muldiv_sequencer_if.slave (Start/Op/operands/HILO_read in,
//          Busy/MulDiv_stall/Done/Div_by_zero/HI/LO out)
// Build option:
//   MULDIV_EARLY_OUT_EN  when defined, a multiply leaves RUN as soon as the
//                        remaining multiplier becomes zero (min one step).
// -----------------------------------------------------------------------------
module muldiv_sequencer #(
  parameter int XLEN = muldiv_pkg::XLEN
) (
  input  logic               Clk,
  input  logic               Rst_n,
  muldiv_sequencer_if.slave  bus
);

  import muldiv_pkg::*;

  localparam int              CNT_W    = $clog2(XLEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

  state_e              r_state;
  state_e              w_state_nxt;
  logic [CNT_W-1:0]    r_cnt;
  op_e                 r_op;
  logic                r_neg_q;   // product or quotient must be negated
  logic                r_neg_r;   // remainder must be negated
  logic                r_dbz;
  logic [2*XLEN-1:0]   r_acc;
  logic [2*XLEN-1:0]   r_opa;
  logic [XLEN-1:0]     r_opb;
  logic [XLEN-1:0]     r_hi;
  logic [XLEN-1:0]     r_lo;

  op_e                 w_op_in;
  logic                w_in_div;
  logic                w_rs_neg;
  logic                w_rt_neg;
  logic [XLEN-1:0]     w_rs_mag;
  logic [XLEN-1:0]     w_rt_mag;
  logic                w_dbz_in;
  logic                w_run_last;
  logic [2*XLEN-1:0]   w_acc_nxt;
  logic [2*XLEN-1:0]   w_opa_nxt;
  logic [XLEN-1:0]     w_opb_nxt;
  logic [2*XLEN-1:0]   w_prod;
  logic [XLEN-1:0]     w_quo;
  logic [XLEN-1:0]     w_rem;
  logic [XLEN-1:0]     w_fix_hi;
  logic [XLEN-1:0]     w_fix_lo;

  // Operand capture: magnitudes and signs. The magnitude of -2^(XLEN-1) is
  // its own bit pattern read as unsigned, which gives the natural result.
  assign w_op_in  = op_e'(bus.Op);
  assign w_in_div = op_is_div(w_op_in);
  assign w_rs_neg = op_is_signed(w_op_in) & bus.Rs_data[XLEN-1];
  assign w_rt_neg = op_is_signed(w_op_in) & bus.Rt_data[XLEN-1];
  assign w_rs_mag = w_rs_neg ? -bus.Rs_data : bus.Rs_data;
  assign w_rt_mag = w_rt_neg ? -bus.Rt_data : bus.Rt_data;
  assign w_dbz_in = w_in_div & (bus.Rt_data == '0);

  muldiv_step #(.XLEN(XLEN)) u_step (
    .i_is_div (op_is_div(r_op)),
    .i_acc    (r_acc),
    .i_opa    (r_opa),
    .i_opb    (r_opb),
    .o_acc    (w_acc_nxt),
    .o_opa    (w_opa_nxt),
    .o_opb    (w_opb_nxt)
  );

`ifdef MULDIV_EARLY_OUT_EN
  // Once the multiplier has been consumed the product cannot change.
  assign w_run_last = (r_cnt == CNT_LAST) |
                      (~op_is_div(r_op) & (w_opb_nxt == '0));
`else
  assign w_run_last = (r_cnt == CNT_LAST);
`endif

  // Sign correction applied on the edge leaving FIX.
  assign w_prod = r_neg_q ? -r_acc : r_acc;
  assign w_quo  = r_neg_q ? -r_acc[XLEN-1:0] : r_acc[XLEN-1:0];
  assign w_rem  = r_neg_r ? -r_acc[2*XLEN-1:XLEN] : r_acc[2*XLEN-1:XLEN];
  assign w_fix_hi = op_is_div(r_op) ? w_rem : w_prod[2*XLEN-1:XLEN];
  assign w_fix_lo = op_is_div(r_op) ? w_quo : w_prod[XLEN-1:0];

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (bus.Start) w_state_nxt = w_dbz_in ? S_DONE : S_RUN;
      S_RUN:  if (w_run_last) w_state_nxt = S_FIX;
      S_FIX:  w_state_nxt = S_DONE;
      S_DONE: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state <= S_IDLE;
    end else begin
      // NOTE: non-blocking assignment so every register samples the values
      // from before the edge, independent of statement order.
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      // NOTE: the whole datapath is cleared, not just control, so HI/LO and
      // the working registers read back as zero after an abort mid-operation.
      r_cnt   <= '0;
      r_op    <= OP_MULT;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_dbz   <= 1'b0;
      r_acc   <= '0;
      r_opa   <= '0;
      r_opb   <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.Start) begin
            r_op    <= w_op_in;
            r_cnt   <= '0;
            r_neg_q <= w_rs_neg ^ w_rt_neg;
            r_neg_r <= w_rs_neg;
            r_dbz   <= w_dbz_in;
            r_acc   <= w_in_div ? {{XLEN{1'b0}}, w_rs_mag} : '0;
            r_opa   <= {{XLEN{1'b0}}, (w_in_div ? w_rt_mag : w_rs_mag)};
            r_opb   <= w_rt_mag;
            if (w_dbz_in) begin
              r_hi <= bus.Rs_data;
              r_lo <= '1;
            end
          end
        end
        S_RUN: begin
          r_acc <= w_acc_nxt;
          r_opa <= w_opa_nxt;
          r_opb <= w_opb_nxt;
          r_cnt <= r_cnt + CNT_W'(1);
        end
        S_FIX: begin
          r_hi <= w_fix_hi;
          r_lo <= w_fix_lo;
        end
        default: ;
      endcase
    end
  end

  assign bus.Busy         = (r_state != S_IDLE);
  assign bus.Done         = (r_state == S_DONE);
  assign bus.Div_by_zero  = (r_state == S_DONE) & r_dbz;
  // DONE is excluded so a waiting mfhi/mflo proceeds in the cycle HI/LO update.
  assign bus.MulDiv_stall = ((r_state == S_RUN) | (r_state == S_FIX)) &
                            (bus.Start | bus.HILO_read);
  assign bus.HI           = r_hi;
  assign bus.LO           = r_lo;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// -----------------------------------------------------------------------------
// tb_muldiv_sequencer
// Self-checking bench for muldiv_sequencer: directed corner cases plus
// randomized operations compared against an arithmetic reference model.
// Cycle k of an operation is the k-th clock period after Start is sampled;
// outputs are sampled just after the falling edge inside that period.
// -----------------------------------------------------------------------------
module tb_muldiv_sequencer;

  localparam int WIN = 38;

  logic Clk;
  logic Rst_n;

  int n_total = 0;
  int n_bad   = 0;

  logic [31:0] m_hi;
  logic [31:0] m_lo;

  muldiv_sequencer_if #(.XLEN(32)) bus ();

  muldiv_sequencer #(.XLEN(32)) dut (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .bus   (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_total++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h want=0x%0h", tag, got, want);
    end
  endtask

  // Architectural result {HI, LO} from plain 64-bit arithmetic.
  function automatic logic [63:0] ref_result(input logic [1:0] op,
                                             input logic [31:0] a,
                                             input logic [31:0] b);
    longint          sa;
    longint          sb;
    longint unsigned ua;
    longint unsigned ub;
    logic [63:0]     p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    p  = '0;
    case (op)
      2'b00: p = 64'(sa * sb);
      2'b01: p = 64'(ua * ub);
      2'b10: begin
        if (b == 0) p = {a, 32'hFFFF_FFFF};
        else        p = {32'(sa % sb), 32'(sa / sb)};
      end
      default: begin
        if (b == 0) p = {a, 32'hFFFF_FFFF};
        else        p = {32'(ua % ub), 32'(ua / ub)};
      end
    endcase
    return p;
  endfunction

  // Cycle in which Done is expected.
  function automatic int exp_done_cycle(input logic [1:0] op, input logic [31:0] b);
    int run;
`ifdef MULDIV_EARLY_OUT_EN
    logic [31:0] mag;
`endif
    if (op[1] && b == 0) return 1;
    run = 32;
`ifdef MULDIV_EARLY_OUT_EN
    // Multiply runs only as many steps as the multiplier magnitude has bits.
    if (!op[1]) begin
      mag = (op == 2'b00 && b[31]) ? -b : b;
      run = 1;
      for (int i = 0; i < 32; i++) if (mag[i]) run = i + 1;
    end
`endif
    return run + 2;
  endfunction

  // One operation; start2 / hilo_from / rst_at are cycle numbers (0 = unused).
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int start2, input int hilo_from, input int rst_at,
                        input string tag);
    logic [63:0] res;
    logic [31:0] old_hi, old_lo, fin_hi, fin_lo, got_hi, got_lo, e_hi, e_lo;
    logic        exp_dbz, gone, e_busy, e_done, e_stall;
    int          exp_cyc, exp_first, first_done, done_cnt;
    int          busy_err, stall_err, dbz_err, hold_err;

    res       = ref_result(op, a, b);
    exp_dbz   = op[1] && (b == 0);
    exp_cyc   = exp_done_cycle(op, b);
    exp_first = (rst_at != 0 && rst_at < exp_cyc) ? 0 : exp_cyc;
    old_hi    = m_hi;
    old_lo    = m_lo;
    fin_hi    = (exp_first != 0) ? res[63:32] : 32'h0;
    fin_lo    = (exp_first != 0) ? res[31:0]  : 32'h0;
    first_done = 0; done_cnt = 0;
    busy_err = 0; stall_err = 0; dbz_err = 0; hold_err = 0;
    got_hi = '0; got_lo = '0;

    @(negedge Clk);
    bus.Start     = 1'b1;
    bus.Op        = op;
    bus.Rs_data   = a;
    bus.Rt_data   = b;
    bus.HILO_read = 1'b0;

    for (int k = 1; k <= WIN; k++) begin
      @(negedge Clk);
      bus.Start     = (k == start2);
      bus.Rs_data   = (k == start2) ? ~a : a;
      bus.HILO_read = (hilo_from != 0 && k >= hilo_from);
      #1;
      gone = (rst_at != 0 && k > rst_at);
      if (gone) begin
        e_busy = 1'b0; e_done = 1'b0; e_hi = '0; e_lo = '0;
      end else begin
        e_busy = (k <= exp_cyc);
        e_done = (k == exp_cyc);
        e_hi   = (k >= exp_cyc) ? res[63:32] : old_hi;
        e_lo   = (k >= exp_cyc) ? res[31:0]  : old_lo;
      end
      e_stall = e_busy && !e_done && (bus.Start || bus.HILO_read);

      if (bus.Done === 1'b1) begin
        done_cnt++;
        if (first_done == 0) begin
          first_done = k;
          got_hi = bus.HI;
          got_lo = bus.LO;
        end
      end
      if (bus.Busy !== e_busy)                    busy_err++;
      if (bus.MulDiv_stall !== e_stall)           stall_err++;
      if (bus.Div_by_zero !== (e_done && exp_dbz)) dbz_err++;
      if ({bus.HI, bus.LO} !== {e_hi, e_lo})      hold_err++;

      if (k == rst_at) begin
        Rst_n = 1'b0;
        #1;
        check({tag, ":rst_busy"},  bus.Busy, 0);
        check({tag, ":rst_done"},  bus.Done, 0);
        check({tag, ":rst_stall"}, bus.MulDiv_stall, 0);
        check({tag, ":rst_hilo"},  {bus.HI, bus.LO}, 0);
        Rst_n = 1'b1;
      end
    end
    bus.Start     = 1'b0;
    bus.HILO_read = 1'b0;

    check({tag, ":done_cycle"}, first_done, exp_first);
    check({tag, ":done_count"}, done_cnt, (exp_first != 0) ? 1 : 0);
    if (exp_first != 0) begin
      check({tag, ":hi_at_done"}, got_hi, res[63:32]);
      check({tag, ":lo_at_done"}, got_lo, res[31:0]);
    end
    check({tag, ":hi_final"}, bus.HI, fin_hi);
    check({tag, ":lo_final"}, bus.LO, fin_lo);
    check({tag, ":busy_errs"},  busy_err, 0);
    check({tag, ":stall_errs"}, stall_err, 0);
    check({tag, ":dbz_errs"},   dbz_err, 0);
    check({tag, ":hilo_errs"},  hold_err, 0);
    m_hi = fin_hi;
    m_lo = fin_lo;
  endtask

  initial begin
    logic [1:0]  op;
    logic [31:0] a, b;
    int          mode;

    Rst_n         = 1'b0;
    bus.Start     = 1'b0;
    bus.Op        = 2'b00;
    bus.Rs_data   = '0;
    bus.Rt_data   = '0;
    bus.HILO_read = 1'b1;
    m_hi = '0;
    m_lo = '0;

    repeat (2) @(negedge Clk);
    check("reset:busy",  bus.Busy, 0);
    check("reset:done",  bus.Done, 0);
    check("reset:dbz",   bus.Div_by_zero, 0);
    check("reset:stall", bus.MulDiv_stall, 0);
    check("reset:hi",    bus.HI, 0);
    check("reset:lo",    bus.LO, 0);
    Rst_n         = 1'b1;
    bus.HILO_read = 1'b0;
    @(negedge Clk);

    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 0, "multu_max");
    run_op(2'b00, -32'sd3, 32'd7,               0, 0, 0, "mult_neg");
    run_op(2'b10, -32'sd7, 32'd2,               0, 0, 0, "div_neg");
    run_op(2'b11, 32'd5, 32'd0,                 0, 0, 0, "divu_zero");
    run_op(2'b10, 32'h8000_0000, 32'd0,         0, 0, 0, "div_zero");
    run_op(2'b01, 32'h1234_5678, 32'hFFFF_FFFF, 5, 10, 0, "stall");
    run_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 0, "mult_min");
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 0, "div_min");
    run_op(2'b00, -32'sd3, 32'd7,               0, 0, 0, "pre_abort");
    run_op(2'b10, 32'd100, 32'd7,               0, 0, 15, "div_abort");
    run_op(2'b11, 32'd1000, 32'd7,              0, 0, 0, "after_abort");
    run_op(2'b01, 32'd3, 32'd1,                 0, 0, 0, "early_out");
    run_op(2'b00, 32'd9, 32'd0,                 0, 0, 0, "mult_by_zero");

    for (int n = 0; n < 24; n++) begin
      op   = 2'($urandom_range(0, 3));
      a    = $urandom;
      b    = $urandom;
      mode = $urandom_range(0, 7);
      case (mode)
        0: b = 32'd0;
        1: b = $urandom_range(1, 15);
        2: a = 32'h8000_0000;
        3: b = -($urandom_range(1, 15));
        default: ;
      endcase
      run_op(op, a, b, 0, 0, 0, $sformatf("rand%0d_op%0d", n, op));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
